// File: rtl/gate_driver_spi_slave_unit_pkg.sv
// Shared constants for the gate-driver SPI slave: frame geometry, register map,
// reset values, LOCK codes and the frame FSM state type.
package gate_driver_spi_slave_unit_pkg;

    localparam int unsigned SPI_FRAME_WIDTH = 16;
    localparam int unsigned REG_W           = 11;
    localparam int unsigned ADDR_LAST_BIT   = 5;

    localparam logic [3:0] ADDR_STATUS1 = 4'h0;
    localparam logic [3:0] ADDR_STATUS2 = 4'h1;
    localparam logic [3:0] ADDR_CTRL2   = 4'h2;
    localparam logic [3:0] ADDR_CTRL3   = 4'h3;
    localparam logic [3:0] ADDR_CTRL4   = 4'h4;
    localparam logic [3:0] ADDR_CTRL5   = 4'h5;
    localparam logic [3:0] ADDR_CTRL6   = 4'h6;

    localparam logic [REG_W-1:0] RST_CTRL2 = 11'h000;
    localparam logic [REG_W-1:0] RST_CTRL3 = 11'h3FF;
    localparam logic [REG_W-1:0] RST_CTRL4 = 11'h7FF;
    localparam logic [REG_W-1:0] RST_CTRL5 = 11'h159;
    localparam logic [REG_W-1:0] RST_CTRL6 = 11'h283;

    localparam logic [2:0] LOCK_CODE   = 3'b110;
    localparam logic [2:0] UNLOCK_CODE = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_ABORT
    } spi_state_e;

endpackage

// File: rtl/gate_driver_spi_slave_unit_sync.sv
// Synchronizer and edge detector for the three asynchronous SPI inputs.
// The nscs chain resets to "selected" so a frame in flight at reset is ignored until a fresh nscs fall.
module spi_slave_sync_unit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_nscs,
    input  logic i_sclk,
    input  logic i_sdi,
    output logic o_nscs_fall,
    output logic o_nscs_rise,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_sdi
);

    logic [SYNC_STAGES-1:0] r_nscs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_nscs_prev;
    logic                   r_sclk_prev;
    logic                   w_nscs;
    logic                   w_sclk;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nscs_sync <= '0;
            r_sclk_sync <= '0;
            r_sdi_sync  <= '0;
            r_nscs_prev <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_nscs_sync <= {r_nscs_sync[SYNC_STAGES-2:0], i_nscs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
            r_nscs_prev <= w_nscs;
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_nscs      = r_nscs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign o_nscs_fall = r_nscs_prev & ~w_nscs;
    assign o_nscs_rise = ~r_nscs_prev & w_nscs;
    assign o_sclk_rise = ~r_sclk_prev & w_sclk;
    assign o_sclk_fall = r_sclk_prev & ~w_sclk;
    assign o_sdi       = r_sdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/gate_driver_spi_slave_unit.sv
// Gate-driver SPI responder: 16-bit mode-1 frames, sticky fault status and control registers.
// Optional register LOCK in ctrl 0x03[10:8] is enabled by GATE_DRIVER_SLAVE_REG_LOCK_EN.
module gate_driver_spi_slave_unit
    import gate_driver_spi_slave_unit_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              spi_nscs_in,
    input  logic              spi_sclk_in,
    input  logic              spi_sdi_in,
    output logic              spi_sdo_out,
    output logic              spi_sdo_oe_out,
    input  logic [REG_W-1:0]  fault_status_1_in,
    input  logic [REG_W-1:0]  fault_status_2_in,
    output logic              nfault_out,
    output logic [REG_W-1:0]  ctrl_reg_2_out,
    output logic [REG_W-1:0]  ctrl_reg_3_out,
    output logic [REG_W-1:0]  ctrl_reg_4_out,
    output logic [REG_W-1:0]  ctrl_reg_5_out,
    output logic [REG_W-1:0]  ctrl_reg_6_out,
    output logic              frame_done_out,
    output logic              frame_error_out
);

    localparam logic [4:0] LP_FRAME = 5'(SPI_FRAME_WIDTH);
    localparam logic [4:0] LP_OVER  = LP_FRAME + 5'd1;
    localparam logic [4:0] LP_SNAP  = 5'(ADDR_LAST_BIT - 1);

    spi_state_e        r_state;
    spi_state_e        w_next;
    logic [4:0]        r_bit_cnt;
    logic [15:0]       r_rx;
    logic [REG_W-1:0]  r_snap;
    logic              r_sdo;
    logic              r_oe;
    logic [REG_W-1:0]  r_sticky1;
    logic [REG_W-1:0]  r_sticky2;
    logic [REG_W-1:0]  r_ctrl2, r_ctrl3, r_ctrl4, r_ctrl5, r_ctrl6;

    logic              w_nscs_fall, w_nscs_rise, w_sclk_rise, w_sclk_fall, w_sdi;
    logic [3:0]        w_addr_early;
    logic [REG_W-1:0]  w_rd_data;
    logic [15:0]       w_tx_word;
    logic [4:0]        w_tx_idx;
    logic              w_tx_bit;
    logic [3:0]        w_addr;
    logic [REG_W-1:0]  w_data;
    logic              w_locked;
    logic              w_wr_en;
    logic              w_wr2, w_wr3, w_wr4, w_wr5, w_wr6;
    logic              w_clr;
    logic              w_any_fault;

    spi_slave_sync_unit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (sys_clk),
        .i_rst       (reset),
        .i_nscs      (spi_nscs_in),
        .i_sclk      (spi_sclk_in),
        .i_sdi       (spi_sdi_in),
        .o_nscs_fall (w_nscs_fall),
        .o_nscs_rise (w_nscs_rise),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_sdi       (w_sdi)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_nscs_fall) w_next = ST_SHIFT;
            ST_SHIFT: if (w_nscs_rise) w_next = (r_bit_cnt == LP_FRAME) ? ST_COMMIT : ST_ABORT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The address is complete on the 5th sampled bit, so it is taken from the live SDI
    assign w_addr_early = {r_rx[2:0], w_sdi};
    assign w_any_fault  = |{r_sticky1, r_sticky2};

    always_comb begin
        w_rd_data = '0;
        case (w_addr_early)
            ADDR_STATUS1: w_rd_data = {w_any_fault, r_sticky1[9:0]};
            ADDR_STATUS2: w_rd_data = r_sticky2;
            ADDR_CTRL2:   w_rd_data = r_ctrl2;
            ADDR_CTRL3:   w_rd_data = r_ctrl3;
            ADDR_CTRL4:   w_rd_data = r_ctrl4;
            ADDR_CTRL5:   w_rd_data = r_ctrl5;
            ADDR_CTRL6:   w_rd_data = r_ctrl6;
            default:      w_rd_data = '0;
        endcase
    end

    // Rise k follows k-1 sampled bits, so it drives bit 15-(k-1); the first rise re-drives bit15
    assign w_tx_word = {5'b0, r_snap};
    assign w_tx_idx  = 5'd15 - r_bit_cnt;
    assign w_tx_bit  = (r_bit_cnt < LP_FRAME) ? w_tx_word[w_tx_idx[3:0]] : 1'b0;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_snap    <= '0;
            r_sdo     <= 1'b0;
            r_oe      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sdo <= 1'b0;
                    r_oe  <= w_nscs_fall;
                    if (w_nscs_fall) begin
                        r_bit_cnt <= '0;
                        r_rx      <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_nscs_rise) begin
                        r_sdo <= 1'b0;
                        r_oe  <= 1'b0;
                    end else begin
                        if (w_sclk_fall && r_bit_cnt != LP_OVER) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt < LP_FRAME) r_rx <= {r_rx[14:0], w_sdi};
                            if (r_bit_cnt == LP_SNAP) r_snap <= w_rd_data;
                        end
                        if (w_sclk_rise) r_sdo <= w_tx_bit;
                    end
                end
                default: begin
                    r_sdo <= 1'b0;
                    r_oe  <= 1'b0;
                end
            endcase
        end
    end

    assign w_addr  = r_rx[14:11];
    assign w_data  = r_rx[10:0];
    assign w_wr_en = (r_state == ST_COMMIT) && !r_rx[15] && !(w_locked && w_addr != ADDR_CTRL3);
    assign w_wr2   = w_wr_en && (w_addr == ADDR_CTRL2);
    assign w_wr3   = w_wr_en && (w_addr == ADDR_CTRL3);
    assign w_wr4   = w_wr_en && (w_addr == ADDR_CTRL4);
    assign w_wr5   = w_wr_en && (w_addr == ADDR_CTRL5);
    assign w_wr6   = w_wr_en && (w_addr == ADDR_CTRL6);
    assign w_clr   = w_wr2 && w_data[0];

`ifdef GATE_DRIVER_SLAVE_REG_LOCK_EN
    logic r_locked;

    always_ff @(posedge sys_clk) begin
        if (reset)                                 r_locked <= 1'b0;
        else if (w_wr3 && w_data[10:8] == LOCK_CODE)   r_locked <= 1'b1;
        else if (w_wr3 && w_data[10:8] == UNLOCK_CODE) r_locked <= 1'b0;
    end

    assign w_locked = r_locked;
`else
    assign w_locked = 1'b0;
`endif

    // Faults are OR-ed in after the clear so an active fault survives CLR_FLT
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_sticky1 <= '0;
            r_sticky2 <= '0;
        end else begin
            r_sticky1 <= (w_clr ? '0 : r_sticky1) | fault_status_1_in;
            r_sticky2 <= (w_clr ? '0 : r_sticky2) | fault_status_2_in;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_ctrl2 <= RST_CTRL2;
            r_ctrl3 <= RST_CTRL3;
            r_ctrl4 <= RST_CTRL4;
            r_ctrl5 <= RST_CTRL5;
            r_ctrl6 <= RST_CTRL6;
        end else begin
            if (w_wr2) r_ctrl2 <= w_data;
            else       r_ctrl2[0] <= 1'b0;
            if (w_wr3) r_ctrl3 <= w_data;
            if (w_wr4) r_ctrl4 <= w_data;
            if (w_wr5) r_ctrl5 <= w_data;
            if (w_wr6) r_ctrl6 <= w_data;
        end
    end

    assign ctrl_reg_2_out  = r_ctrl2;
    assign ctrl_reg_3_out  = r_ctrl3;
    assign ctrl_reg_4_out  = r_ctrl4;
    assign ctrl_reg_5_out  = r_ctrl5;
    assign ctrl_reg_6_out  = r_ctrl6;
    assign nfault_out      = ~w_any_fault;
    assign frame_done_out  = (r_state == ST_COMMIT);
    assign frame_error_out = (r_state == ST_ABORT);
    assign spi_sdo_oe_out  = r_oe & ~spi_nscs_in;
    assign spi_sdo_out     = r_sdo & ~spi_nscs_in;

endmodule

// File: tb/tb_gate_driver_spi_slave_unit.sv
// Scoreboard bench for gate_driver_spi_slave_unit: SPI master tasks, register-map model, pulse monitor.
module tb_gate_driver_spi_slave_unit;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        nscs, sclk, sdi;
    logic [10:0] f1, f2;
    logic        sdo, sdo_oe, nfault, done, err;
    logic [10:0] c2, c3, c4, c5, c6;

    always #5 sys_clk = ~sys_clk;

    gate_driver_spi_slave_unit #(.SYNC_STAGES(2)) dut (
        .sys_clk           (sys_clk),
        .reset             (reset),
        .spi_nscs_in       (nscs),
        .spi_sclk_in       (sclk),
        .spi_sdi_in        (sdi),
        .spi_sdo_out       (sdo),
        .spi_sdo_oe_out    (sdo_oe),
        .fault_status_1_in (f1),
        .fault_status_2_in (f2),
        .nfault_out        (nfault),
        .ctrl_reg_2_out    (c2),
        .ctrl_reg_3_out    (c3),
        .ctrl_reg_4_out    (c4),
        .ctrl_reg_5_out    (c5),
        .ctrl_reg_6_out    (c6),
        .frame_done_out    (done),
        .frame_error_out   (err)
    );

`ifdef GATE_DRIVER_SLAVE_REG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct packed {
        bit               is_err;
        bit               chk_resp;
        logic [15:0]      resp;
        logic [4:0][10:0] ctrl;
    } exp_t;

    exp_t        q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_done = 0;
    bit          mon_busy = 1'b0;
    logic [15:0] tb_resp;

    logic [10:0] m_ctrl [16];
    logic [10:0] m_s1, m_s2;
    bit          m_locked;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ctrl[i] = '0;
        m_ctrl[3] = 11'h3FF; m_ctrl[4] = 11'h7FF; m_ctrl[5] = 11'h159; m_ctrl[6] = 11'h283;
        m_s1 = '0; m_s2 = '0; m_locked = 1'b0;
    endtask

    function automatic logic [10:0] m_read(input int a);
        if (a == 0) return {(m_s1 != 0 || m_s2 != 0), m_s1[9:0]};
        if (a == 1) return m_s2;
        if (a >= 2 && a <= 6) return m_ctrl[a];
        return '0;
    endfunction

    task automatic model_commit(input logic [15:0] w);
        int a = int'(w[14:11]);
        logic [10:0] d = w[10:0];
        if (w[15] || a < 2 || a > 6) return;
        if (LOCK_EN && m_locked && a != 3) return;
        m_ctrl[a] = d;
        if (a == 2) begin
            m_ctrl[2][0] = 1'b0;
            if (d[0]) begin m_s1 = f1; m_s2 = f2; end
        end
        if (LOCK_EN && a == 3) begin
            if (d[10:8] == 3'b110) m_locked = 1'b1;
            else if (d[10:8] == 3'b011) m_locked = 1'b0;
        end
    endtask

    task automatic sclk_bit(input logic b, input int idx);
        sclk = 1'b1; sdi = b;
        #80;
        if (idx < 16) tb_resp[15-idx] = sdo;
        sclk = 1'b0;
        #80;
    endtask

    task automatic spi_xfer(input logic [15:0] w, input int nbits);
        tb_resp = '0;
        nscs = 1'b0;
        #160;
        for (int i = 0; i < nbits; i++) sclk_bit((i < 16) ? w[15-i] : 1'b0, i);
        #160;
        nscs = 1'b1;
        sdi  = 1'b0;
        #160;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || mon_busy) && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= 200) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d expected pulses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic frame(input logic [15:0] w, input int nbits);
        exp_t e;
        e.chk_resp = (nbits >= 16);
        e.resp     = {5'b0, m_read(int'(w[14:11]))};
        e.is_err   = (nbits != 16);
        if (nbits == 16) model_commit(w);
        for (int i = 0; i < 5; i++) e.ctrl[i] = m_ctrl[i+2];
        q.push_back(e);
        spi_xfer(w, nbits);
        drain();
    endtask

    task automatic pulse_fault(input logic [10:0] a, input logic [10:0] b);
        @(negedge sys_clk);
        f1 = a; f2 = b;
        @(negedge sys_clk);
        f1 = '0; f2 = '0;
        m_s1 |= a; m_s2 |= b;
        check("nfault_after_pulse", nfault, (m_s1 != 0 || m_s2 != 0) ? 1'b0 : 1'b1);
    endtask

    task automatic check_reset_outputs();
        check("rst_done", done, 0);
        check("rst_error", err, 0);
        check("rst_sdo", sdo, 0);
        check("rst_sdo_oe", sdo_oe, 0);
        check("rst_nfault", nfault, 1);
        check("rst_ctrl2", c2, 11'h000);
        check("rst_ctrl3", c3, 11'h3FF);
        check("rst_ctrl4", c4, 11'h7FF);
        check("rst_ctrl5", c5, 11'h159);
        check("rst_ctrl6", c6, 11'h283);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (done || err) begin
                mon_busy = 1'b1;
                if (done) n_done++;
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b, expected none", done, err);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", {14'b0, done, err}, e.is_err ? 16'h1 : 16'h2);
                    if (e.chk_resp) check("read_resp", tb_resp, e.resp);
                    repeat (2) @(negedge sys_clk);
                    check("ctrl2", c2, e.ctrl[0]);
                    check("ctrl3", c3, e.ctrl[1]);
                    check("ctrl4", c4, e.ctrl[2]);
                    check("ctrl5", c5, e.ctrl[3]);
                    check("ctrl6", c6, e.ctrl[4]);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int unsigned d0;
        logic [15:0] w;
        int nb;
        reset = 1'b1; nscs = 1'b1; sclk = 1'b0; sdi = 1'b0; f1 = '0; f2 = '0;
        model_reset();
        repeat (5) @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
        check_reset_outputs();

        // write 0x155 to address 5, then read it back
        d0 = n_done;
        frame(16'h2800 | 16'h0155, 16);
        frame(16'hA800, 16);
        check("two_done_pulses", 16'(n_done - d0), 16'd2);
        check("ctrl5_after_write", c5, 11'h155);

        // one-cycle fault, status1 read, clear with fault gone
        pulse_fault(11'h008, 11'h000);
        frame(16'h8000, 16);
        frame(16'h1001, 16);
        check("nfault_cleared", nfault, 1);
        frame(16'h8000, 16);

        // clear while fault held: bit stays set
        @(negedge sys_clk);
        f1 = 11'h008;
        m_s1 |= 11'h008;
        frame(16'h1001, 16);
        f1 = '0;
        frame(16'h8000, 16);
        check("nfault_held", nfault, 0);
        frame(16'h1001, 16);

        // short frame aborts
        d0 = n_done;
        frame(16'h2800 | 16'h00AA, 9);
        check("no_done_on_abort", 16'(n_done - d0), 16'd0);

`ifdef GATE_DRIVER_SLAVE_REG_LOCK_EN
        frame(16'h1800 | 16'h06FF, 16);
        frame(16'h2000, 16);
        check("ctrl4_locked", c4, 11'h7FF);
        frame(16'h1800 | 16'h03FF, 16);
        frame(16'h2000, 16);
        check("ctrl4_unlocked", c4, 11'h000);
`endif

        // reset in the middle of a frame at bit 7
        nscs = 1'b0;
        #160;
        for (int i = 0; i < 7; i++) sclk_bit(1'b1, i);
        @(negedge sys_clk);
        reset = 1'b1;
        repeat (4) @(negedge sys_clk);
        reset = 1'b0;
        model_reset();
        @(negedge sys_clk);
        check_reset_outputs();
        for (int i = 7; i < 16; i++) sclk_bit(1'b0, i);
        #160;
        nscs = 1'b1;
        #400;
        frame(16'hA800, 16);
        frame(16'h3000 | 16'h0123, 16);

        // randomized frames, faults and malformed lengths
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0)
                pulse_fault(11'(1 << $urandom_range(0, 10)), ($urandom_range(0, 1) == 1) ? 11'($urandom) : 11'h000);
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[14:11] = 4'($urandom_range(0, 6));
            case ($urandom_range(0, 9))
                0: nb = 3;
                1: nb = 15;
                2: nb = 17;
                default: nb = 16;
            endcase
            frame(w, nb);
        end

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
